// File: rtl/alu_shift_pkg.sv
// Shared definitions for the multi-cycle shift ALU sequencer: opcodes, FSM states, opcode legality.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package alu_shift_pkg;

  // Shift opcodes as presented on req_op
  localparam logic [3:0] OP_SHL = 4'b0000;
  localparam logic [3:0] OP_SHR = 4'b0001;
  localparam logic [3:0] OP_SAR = 4'b0010;
  localparam logic [3:0] OP_SAL = 4'b0011;

  // Controller states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // True for the four opcodes the shifter implements
  function automatic logic is_legal_op(input logic [3:0] op);
    return (op == OP_SHL) || (op == OP_SHR) || (op == OP_SAR) || (op == OP_SAL);
  endfunction

endpackage

// File: rtl/shift_step.sv
// Single-bit shift step: advances the accumulator by one position for the given opcode.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the controller decides when the result is committed.
module shift_step
  import alu_shift_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] acc,
  output logic [WIDTH-1:0] acc_next,
  output logic             bit_out,
  output logic             sign_flip
);

  // One-position shift; sal is identical to shl in data, it differs only in overflow tracking
  always_comb begin
    acc_next = acc;
    bit_out  = 1'b0;
    case (op)
      OP_SHL, OP_SAL: begin
        acc_next = {acc[WIDTH-2:0], 1'b0};
        bit_out  = acc[WIDTH-1];
      end
      OP_SHR: begin
        acc_next = {1'b0, acc[WIDTH-1:1]};
        bit_out  = acc[0];
      end
      OP_SAR: begin
        acc_next = {acc[WIDTH-1], acc[WIDTH-1:1]};
        bit_out  = acc[0];
      end
      default: begin
        acc_next = acc;
        bit_out  = 1'b0;
      end
    endcase
  end

  // A change of the top bit across one step is what signed overflow means for a left shift
  assign sign_flip = acc_next[WIDTH-1] ^ acc[WIDTH-1];

endmodule

// File: rtl/shift_alu_ctrl.sv
// Multi-cycle shift sequencer: accepts one request, shifts one bit per cycle, returns result and flags.
// Latency: rsp_valid is seen n+1 cycles after the accept edge inclusive, n = min(req_b, WIDTH); illegal opcode 1.
// Backpressure: req_ready only in IDLE without flush; response held stable until rsp_ready, flush aborts.
module shift_alu_ctrl
  import alu_shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int AMT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic             flush,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_out,
  output logic             rsp_carry,
  output logic             rsp_ovf,
  output logic             rsp_zero,
  output logic             rsp_neg,
  output logic             rsp_illegal,
  output logic             busy
);

  state_t             state;
  logic [3:0]         op_q;
  logic [WIDTH-1:0]   acc;
  logic [AMT_W-1:0]   cnt;
  logic               carry_q;
  logic               ovf_q;
  logic               zero_q;
  logic               neg_q;
  logic               illegal_q;

  logic [WIDTH-1:0]   step_acc;
  logic               step_bit;
  logic               step_flip;

  logic               accept;
  logic               legal_in;
  logic [AMT_W-1:0]   cnt_init;
  logic               in_done;

  shift_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .op        (op_q),
    .acc       (acc),
    .acc_next  (step_acc),
    .bit_out   (step_bit),
    .sign_flip (step_flip)
  );

  // Flush outranks a pending request in IDLE, so it also closes the ready window
  assign accept   = (state == IDLE) && req_valid && !flush;
  assign legal_in = is_legal_op(req_op);

  // Amounts of WIDTH or more saturate; after WIDTH steps the result no longer changes shape
  always_comb begin
    cnt_init = AMT_W'(WIDTH);
    if (req_b < WIDTH'(WIDTH)) begin
      cnt_init = req_b[AMT_W-1:0];
    end
  end

  // Controller FSM, shift datapath and registered response flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_q      <= OP_SHL;
      acc       <= '0;
      cnt       <= '0;
      carry_q   <= 1'b0;
      ovf_q     <= 1'b0;
      zero_q    <= 1'b0;
      neg_q     <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q      <= req_op;
            acc       <= req_a;
            cnt       <= cnt_init;
            carry_q   <= 1'b0;
            ovf_q     <= 1'b0;
            illegal_q <= !legal_in;
            if (!legal_in || (cnt_init == '0)) begin
              // Nothing to shift: the operand itself is the answer
              zero_q <= (req_a == '0);
              neg_q  <= req_a[WIDTH-1];
              state  <= DONE;
            end else begin
              state  <= SHIFT;
            end
          end
        end

        SHIFT: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            acc     <= step_acc;
            carry_q <= step_bit;
            if ((op_q == OP_SAL) && step_flip) begin
              ovf_q <= 1'b1;
            end
            cnt <= cnt - AMT_W'(1);
            if (cnt == AMT_W'(1)) begin
              zero_q <= (step_acc == '0);
              neg_q  <= step_acc[WIDTH-1];
              state  <= DONE;
            end
          end
        end

        DONE: begin
          // A flush in the same cycle as rsp_ready means the response was not delivered
          if (flush || rsp_ready) begin
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign in_done     = (state == DONE);
  assign busy        = (state != IDLE);
  assign req_ready   = (state == IDLE) && !flush;
  assign rsp_valid   = in_done;
  assign rsp_out     = acc;
  assign rsp_carry   = carry_q   & in_done;
  assign rsp_ovf     = ovf_q     & in_done;
  assign rsp_zero    = zero_q    & in_done;
  assign rsp_neg     = neg_q     & in_done;
  assign rsp_illegal = illegal_q & in_done;

endmodule

// File: tb/tb_shift_alu_ctrl.sv
// Scoreboard bench for shift_alu_ctrl: driver pushes model results, monitor pops on each response.
// Reference model computes shifts over a 64-bit window in one step, not bit by bit.
// Response backpressure is produced by a separate process with selectable modes.
module tb_shift_alu_ctrl;
  import alu_shift_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid;
  logic         req_ready;
  logic [3:0]   req_op;
  logic [W-1:0] req_a;
  logic [W-1:0] req_b;
  logic         flush;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_out;
  logic         rsp_carry;
  logic         rsp_ovf;
  logic         rsp_zero;
  logic         rsp_neg;
  logic         rsp_illegal;
  logic         busy;

  shift_alu_ctrl #(.WIDTH(W), .AMT_W(6)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_a       (req_a),
    .req_b       (req_b),
    .flush       (flush),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_out     (rsp_out),
    .rsp_carry   (rsp_carry),
    .rsp_ovf     (rsp_ovf),
    .rsp_zero    (rsp_zero),
    .rsp_neg     (rsp_neg),
    .rsp_illegal (rsp_illegal),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] out;
    logic         carry;
    logic         ovf;
    logic         zero;
    logic         neg;
    logic         illegal;
    int           lat;
    int           acc_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   edge_cnt = 0;
  int   rr_mode = 0;   // 0: always ready, 1: random, 2: hold low

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out (t=%0t)", name, $time);
  endtask

  // Whole-operation reference: shift a 64-bit window by n at once and read the result and last bit out
  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t        e;
    int          n;
    logic [63:0] t;
    logic [63:0] win;
    n         = (b >= 32'd32) ? 32 : int'(b);
    e.out     = a;
    e.carry   = 1'b0;
    e.ovf     = 1'b0;
    e.illegal = 1'b0;
    e.lat     = n + 1;
    e.acc_cyc = 0;
    if (op > 4'd3) begin
      e.illegal = 1'b1;
      e.lat     = 1;
    end else if (op == 4'd1) begin
      t     = {a, 32'h0} >> n;
      e.out = t[63:32];
      if (n > 0) e.carry = t[31];
    end else if (op == 4'd2) begin
      t     = $signed({a, 32'h0}) >>> n;
      e.out = t[63:32];
      if (n > 0) e.carry = t[31];
    end else begin
      t     = {32'h0, a} << n;
      e.out = t[31:0];
      if (n > 0) e.carry = t[32];
      if (op == 4'd3) begin
        // Overflow iff the sign bit took more than one value over the sequence of results
        win = {a, 32'h0};
        for (int k = 1; k <= n; k++) begin
          if (win[63-k] != win[63]) e.ovf = 1'b1;
        end
      end
    end
    e.zero = (e.out == '0);
    e.neg  = e.out[W-1];
    return e;
  endfunction

  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int   guard;
    guard = 0;
    e = model(op, a, b);
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    #1;
    while (!req_ready) begin
      guard++;
      if (guard > 300) begin
        timeout("accept");
        req_valid = 1'b0;
        return;
      end
      @(negedge clk);
      #1;
    end
    e.acc_cyc = edge_cnt + 1;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    do begin
      @(negedge clk);
      #3;
      g++;
    end while ((busy || exp_q.size() != 0) && g < 400);
    if (g >= 400) timeout("drain");
  endtask

  // Response-side backpressure generator
  initial begin
    rsp_ready = 1'b1;
    forever begin
      @(negedge clk);
      case (rr_mode)
        0:       rsp_ready = 1'b1;
        1:       rsp_ready = 1'($urandom_range(0, 1));
        default: rsp_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pop on each new response, check every cycle it is presented
  initial begin
    exp_t cur;
    bit   in_rsp;
    bit   have;
    in_rsp = 1'b0;
    have   = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        in_rsp = 1'b0;
        have   = 1'b0;
      end else if (rsp_valid) begin
        if (!in_rsp) begin
          in_rsp = 1'b1;
          if (exp_q.size() == 0) begin
            have = 1'b0;
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_rsp: got rsp_valid=1 out=0x%08h, want no response", rsp_out);
          end else begin
            have = 1'b1;
            cur  = exp_q.pop_front();
            chk("latency", 32'(edge_cnt - cur.acc_cyc + 1), 32'(cur.lat));
          end
        end
        if (have) begin
          chk("out", rsp_out, cur.out);
          chk("carry", 32'(rsp_carry), 32'(cur.carry));
          chk("ovf", 32'(rsp_ovf), 32'(cur.ovf));
          chk("zero", 32'(rsp_zero), 32'(cur.zero));
          chk("neg", 32'(rsp_neg), 32'(cur.neg));
          chk("illegal", 32'(rsp_illegal), 32'(cur.illegal));
          chk("req_ready_in_done", 32'(req_ready), 32'd0);
        end
      end else begin
        in_rsp = 1'b0;
        have   = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [3:0]   rop;
    int           sel;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_op    = 4'h0;
    req_a     = '0;
    req_b     = '0;
    flush     = 1'b0;
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out", rsp_out, 32'h0);
    chk("rst_flags", 32'({rsp_carry, rsp_ovf, rsp_zero, rsp_neg, rsp_illegal}), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Directed operations
    issue(OP_SHL, 32'h8000_0001, 32'd1);
    issue(OP_SAR, 32'h8000_0000, 32'd4);
    issue(OP_SAL, 32'h4000_0000, 32'd1);
    issue(OP_SHR, 32'h1234_5678, 32'd0);
    issue(4'b0111, 32'h1234_5678, 32'd5);
    issue(OP_SHR, 32'hFFFF_FFFF, 32'd40);
    issue(OP_SAR, 32'hFFFF_FFFF, 32'd40);
    issue(OP_SAL, 32'h0000_0001, 32'd32);
    issue(OP_SHL, 32'h0000_0000, 32'd3);
    wait_idle();

    // Held response: outputs stay put, new requests are refused
    rr_mode = 2;
    issue(OP_SHL, 32'h0000_00F1, 32'd3);
    begin
      int g;
      g = 0;
      while (!rsp_valid && g < 50) begin
        @(negedge clk);
        #3;
        g++;
      end
      if (g >= 50) timeout("hold_wait");
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      req_valid = 1'b1;
      req_op    = OP_SHR;
      req_a     = 32'hDEAD_BEEF;
      req_b     = 32'd2;
      #1;
      chk("hold_req_ready", 32'(req_ready), 32'd0);
      chk("hold_busy", 32'(busy), 32'd1);
    end
    @(negedge clk);
    req_valid = 1'b0;
    rr_mode   = 0;
    issue(OP_SAR, 32'h8765_4321, 32'd8);
    wait_idle();

    // Flush mid-shift drops the operation
    issue(OP_SAL, 32'h1357_9BDF, 32'd20);
    repeat (7) @(negedge clk);
    flush = 1'b1;
    exp_q.delete();
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_rsp_valid", 32'(rsp_valid), 32'd0);
    repeat (4) @(negedge clk);
    issue(OP_SHL, 32'h0F0F_0F0F, 32'd4);
    wait_idle();

    // Flush outranks a request presented in IDLE
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = OP_SHL;
    req_a     = 32'h1;
    req_b     = 32'd1;
    flush     = 1'b1;
    #1;
    chk("flush_idle_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    flush     = 1'b0;
    #1;
    chk("flush_idle_busy", 32'(busy), 32'd0);

    // Asynchronous reset mid-shift
    issue(OP_SAL, 32'hA5A5_0001, 32'd20);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("arst_req_ready", 32'(req_ready), 32'd1);
    chk("arst_out", rsp_out, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue(OP_SHR, 32'hF000_000F, 32'd2);
    wait_idle();

    // Randomised traffic with random response backpressure
    rr_mode = 1;
    for (int i = 0; i < 80; i++) begin
      sel = int'($urandom_range(0, 9));
      rop = (sel == 9) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
      ra  = $urandom;
      sel = int'($urandom_range(0, 9));
      if (sel == 0)      rb = 32'd0;
      else if (sel == 1) rb = 32'd32 + $urandom_range(0, 100);
      else if (sel == 2) rb = $urandom;
      else               rb = $urandom_range(1, 31);
      issue(rop, ra, rb);
    end
    wait_idle();
    rr_mode = 0;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
